// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: a pipelined bitwise logic unit with valid/ready handshakes on
// both sides and a counter of completed output transfers.
// Every pipeline slot holds a valid bit and the result word. The last slot also
// holds the zero flag and the population count, so all outputs change together.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic [2:0]                 OP,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           Y,
    output logic                       Z,
    output logic [$clog2(WIDTH+1)-1:0] ONES,
    output logic [CNT_W-1:0]           txn_count
);

    localparam int OW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Pipeline state. Slot STAGES-1 drives the outputs.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  y_q [STAGES];
    logic [WIDTH-1:0]  y_d [STAGES];
    logic              z_q, z_d;
    logic [OW-1:0]     ones_q, ones_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Combinational helpers
    logic [WIDTH-1:0]  func_y;
    logic [STAGES-1:0] adv;        // slot k hands its contents onward this cycle
    logic [STAGES-1:0] load;       // slot k takes new contents from its source
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_y [STAGES];
    logic [OW-1:0]     pop_last;

    // Function mux. Every OP code decodes to a defined function.
    always_comb begin
        // NOTE: a default value is assigned before the case so that no path
        // leaves func_y unassigned, which would otherwise infer a latch.
        func_y = '0;
        case (op_e'(OP))
            OP_AND:  func_y = A & B;
            OP_OR:   func_y = A | B;
            OP_NAND: func_y = ~(A & B);
            OP_NOR:  func_y = ~(A | B);
            OP_XOR:  func_y = A ^ B;
            OP_XNOR: func_y = ~(A ^ B);
            OP_NOTA: func_y = ~A;
            OP_PASS: func_y = A;
            default: func_y = '0;
        endcase
    end

    // Flow control. A slot advances when the consumer is ready or when some slot
    // further downstream is empty, because the pipeline then compacts by one.
    always_comb begin
        logic hole;
        hole = 1'b0;
        adv  = '0;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = out_ready | hole;
            load[k] = ~valid_q[k] | adv[k];
            hole    = hole | ~valid_q[k];
        end
    end

    // Source of each slot: the function result for slot 0, otherwise the previous slot.
    always_comb begin
        src_v[0] = in_valid;
        src_y[0] = func_y;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = valid_q[k-1];
            src_y[k] = y_q[k-1];
        end
    end

    // Population count of the word that is about to enter the last slot
    always_comb begin
        pop_last = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_last = pop_last + OW'(src_y[STAGES-1][i]);
        end
    end

    // Next-state logic. Data moves only with a valid beat, so an empty slot keeps its last word.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        z_d     = z_q;
        ones_d  = ones_q;
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = src_v[k];
                if (src_v[k]) begin
                    y_d[k] = src_y[k];
                end
            end
        end
        if (load[STAGES-1] && src_v[STAGES-1]) begin
            z_d    = ~|src_y[STAGES-1];
            ones_d = pop_last;
        end
        cnt_d = cnt_q + CNT_W'(out_valid && out_ready);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            // NOTE: the data slots are reset as well, not only the valid bits,
            // because Y must read as zero after reset. The array is small.
            for (int k = 0; k < STAGES; k++) begin
                y_q[k] <= '0;
            end
            z_q    <= 1'b1;
            ones_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every slot sample its pre-edge
            // neighbour, so the shift happens in parallel and does not ripple.
            valid_q <= valid_d;
            y_q     <= y_d;
            z_q     <= z_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign Y         = y_q[STAGES-1];
    assign Z         = z_q;
    assign ONES      = ones_q;
    assign txn_count = cnt_q;

endmodule
